rps_round_ctrl: RTL

Round sequencer for the two-player rock-paper-scissors game. It takes single-cycle action pulses from the button debouncers and the CPU player, and steps each round through select, lock, reveal and scoring. It owns both players' choices and scores. It sits between the debouncer/CPU-player blocks and the display/LED drivers in `top`.

---
 rtl/rps_pkg.sv | 37 +++
 rtl/rps_player_slot.sv | 55 +++++
 rtl/rps_round_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared types and helpers for the rock-paper-scissors round sequencer.
package rps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_REVEAL     = 3'd2,
    ST_RESULT     = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  localparam logic [1:0] ROCK     = 2'd0;
  localparam logic [1:0] PAPER    = 2'd1;
  localparam logic [1:0] SCISSORS = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Winner code from d = (c1 - c2 + 3) mod 3; choices are always 0..2.
  function automatic logic [1:0] rps_result(input logic [1:0] c1, input logic [1:0] c2);
    logic [2:0] d;
    d = 3'(c1) + 3'd3 - 3'(c2);
    if (d >= 3'd3) d = d - 3'd3;
    case (d)
      3'd1:    rps_result = WIN_P1;
      3'd2:    rps_result = WIN_P2;
      default: rps_result = WIN_NONE;
    endcase
  endfunction

  // The CPU may present the unused code 3; it is treated as rock.
  function automatic logic [1:0] sanitize_choice(input logic [1:0] c);
    sanitize_choice = (c == 2'd3) ? ROCK : c;
  endfunction

endpackage

// File: rtl/rps_player_slot.sv
// One player's choice register and lock flag with select/confirm handling.
// Inputs arrive already qualified by the sequencer (SELECT state, mode).
module rps_player_slot
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       sel_i,
  input  logic       conf_i,
  input  logic       load_i,
  input  logic [1:0] load_choice_i,
  output logic [1:0] choice_o,
  output logic       locked_o
);

  logic [1:0] choice_q, choice_d;
  logic       locked_q, locked_d;

  // Next choice/lock: clear wins, then a direct load, then confirm over select.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    choice_d = choice_q;
    locked_d = locked_q;
    if (clear_i) begin
      choice_d = ROCK;
      locked_d = 1'b0;
    end else if (!locked_q) begin
      if (load_i) begin
        choice_d = load_choice_i;
        locked_d = 1'b1;
      end else if (conf_i) begin
        locked_d = 1'b1;
      end else if (sel_i) begin
        choice_d = (choice_q == SCISSORS) ? ROCK : choice_q + 2'd1;
      end
    end
  end

  // Choice and lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      choice_q <= ROCK;
      locked_q <= 1'b0;
    end else begin
      choice_q <= choice_d;
      locked_q <= locked_d;
    end
  end

  assign choice_o = choice_q;
  assign locked_o = locked_q;

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: select, lock, reveal hold, scoring and match end.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int REVEAL_CYCLES = 100_000_000,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               sel1_p,
  input  logic               conf1_p,
  input  logic               sel2_p,
  input  logic               conf2_p,
  input  logic               start_p,
  input  logic [1:0]         cpu_choice,
  input  logic               cpu_valid,
  output logic [2:0]         state_o,
  output logic [1:0]         choice1_o,
  output logic [1:0]         choice2_o,
  output logic               locked1_o,
  output logic               locked2_o,
  output logic               reveal_o,
  output logic [1:0]         winner_o,
  output logic [SCORE_W-1:0] score1_o,
  output logic [SCORE_W-1:0] score2_o,
  output logic               match_over_o
);

  localparam int                CNT_W    = $clog2(REVEAL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               clear_slots;
  logic               in_select;
  logic [1:0]         result;

  assign in_select = (state_q == ST_SELECT);
  assign result    = rps_result(choice1_o, choice2_o);

  // Next-state and datapath updates for the round sequence.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    clear_slots = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          mode_d      = mode;
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = WIN_NONE;
          clear_slots = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (locked1_o && locked2_o) begin
          cnt_d   = '0;
          state_d = ST_REVEAL;
        end
      end
      ST_REVEAL: begin
        if (cnt_q == CNT_LAST) state_d = ST_RESULT;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESULT: begin
        winner_d = result;
        if (result == WIN_P1) score1_d = score1_q + SCORE_W'(1);
        if (result == WIN_P2) score2_d = score2_q + SCORE_W'(1);
        if (score1_d == WIN_VAL || score2_d == WIN_VAL) begin
          state_d = ST_MATCH_OVER;
        end else begin
          clear_slots = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_MATCH_OVER: begin
        if (start_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, mode latch, reveal counter, winner and scores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      winner_q <= WIN_NONE;
      score1_q <= '0;
      score2_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end
  end

  rps_player_slot u_slot1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_slots),
    .sel_i         (sel1_p & in_select),
    .conf_i        (conf1_p & in_select),
    .load_i        (1'b0),
    .load_choice_i (ROCK),
    .choice_o      (choice1_o),
    .locked_o      (locked1_o)
  );

  // In CPU mode the P2 buttons are masked and the CPU strobe loads the slot.
  rps_player_slot u_slot2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_slots),
    .sel_i         (sel2_p & in_select & ~mode_q),
    .conf_i        (conf2_p & in_select & ~mode_q),
    .load_i        (cpu_valid & in_select & mode_q),
    .load_choice_i (sanitize_choice(cpu_choice)),
    .choice_o      (choice2_o),
    .locked_o      (locked2_o)
  );

  assign state_o      = state_q;
  assign reveal_o     = (state_q == ST_REVEAL) || (state_q == ST_RESULT);
  assign match_over_o = (state_q == ST_MATCH_OVER);
  assign winner_o     = winner_q;
  assign score1_o     = score1_q;
  assign score2_o     = score2_q;

endmodule
